sar_search_ctrl: RTL

Successive-approximation search controller that finds an unknown unsigned operand by binary search.
- Drives valB of the downstream magnitude comparator. The unknown value sits on the comparator's valA.
- Consumes the comparator's aLTb/aEQb/aGTb flags and narrows the range by one probe per clock.
- Reports the found value and the probe count.
- Used as the lab "guess the number" stage around the 3-bit comparator.

---
 rtl/sar_search_ctrl_if.sv | 36 +++
 rtl/sar_search_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : sar_search_ctrl_if
// Description : Handshake and comparator bundle between the successive-
//               approximation search controller and its environment.
//               The master side is the controller; the slave side holds the
//               magnitude comparator and the start requester.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sar_search_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             aLTb;
  logic             aEQb;
  logic             aGTb;
  logic [WIDTH-1:0] valB;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] found;
  logic [3:0]       steps;

  modport master (
    input  start, aLTb, aEQb, aGTb,
    output valB, busy, done, err, found, steps
  );

  modport slave (
    output start, aLTb, aEQb, aGTb,
    input  valB, busy, done, err, found, steps
  );
endinterface

`default_nettype wire

// File: rtl/sar_search_ctrl.sv
//------------------------------------------------------------------------------
// Module      : sar_search_ctrl
// Description : Binary-search controller that finds the unknown operand on a
//               magnitude comparator's valA by driving valB, one probe per
//               clock, flag priority EQ > LT > GT.
//               Optional macro SAR_FLAG_CHECK_EN: when defined, any sampled
//               flag set that is not exactly one-hot ends the search in ERR.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sar_search_ctrl #(
  parameter int WIDTH = 3
) (
  input  wire              clk,
  input  wire              rst_n,
  sar_search_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   lo_q, lo_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] valb_q, valb_d;
  logic [WIDTH-1:0] found_q, found_d;
  logic [3:0]       steps_q, steps_d;
  logic [2:0]       w_flags;

  // Midpoint of the inclusive range; the sum needs one extra bit, and the
  // halved value always fits back into WIDTH bits because hi < 2^WIDTH.
  function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH:0] lo,
                                               input logic [WIDTH:0] hi);
    logic [WIDTH+1:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[WIDTH:1];
  endfunction

  assign w_flags = {bus.aLTb, bus.aEQb, bus.aGTb};

  // State and datapath registers; reset clears every visible result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      valb_q  <= '0;
      found_q <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      valb_q  <= valb_d;
      found_q <= found_d;
      steps_q <= steps_d;
    end
  end

  // Next-state: start a search from the idle-like states, otherwise narrow
  // the range using the flags produced by the probe currently on valB.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    valb_d  = valb_q;
    found_d = found_q;
    steps_d = steps_q;
    case (state_q)
      S_EVAL: begin
        steps_d = steps_q + 4'd1;
`ifdef SAR_FLAG_CHECK_EN
        if (!$onehot(w_flags)) begin
          state_d = S_ERR;
        end else
`endif
        if (bus.aEQb) begin
          found_d = valb_q;
          state_d = S_DONE;
        end else if (bus.aLTb) begin
          if ({1'b0, valb_q} == lo_q) begin
            state_d = S_ERR;
          end else begin
            hi_d   = {1'b0, valb_q} - {{WIDTH{1'b0}}, 1'b1};
            valb_d = mid_of(lo_q, hi_d);
          end
        end else if (bus.aGTb) begin
          if ({1'b0, valb_q} == hi_q) begin
            state_d = S_ERR;
          end else begin
            lo_d   = {1'b0, valb_q} + {{WIDTH{1'b0}}, 1'b1};
            valb_d = mid_of(lo_d, hi_q);
          end
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        if (bus.start) begin
          lo_d    = '0;
          hi_d    = {1'b0, {WIDTH{1'b1}}};
          valb_d  = {1'b0, {(WIDTH-1){1'b1}}};
          steps_d = '0;
          state_d = S_EVAL;
        end
      end
    endcase
  end

  assign bus.valB  = valb_q;
  assign bus.found = found_q;
  assign bus.steps = steps_q;
  assign bus.busy  = (state_q == S_EVAL);
  assign bus.done  = (state_q == S_DONE);
  assign bus.err   = (state_q == S_ERR);

endmodule

`default_nettype wire
